// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-source mux scan/capture stage.
package mux_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int SEL_W = 2;
   localparam logic [SEL_W-1:0] LAST_IDX = 2'd3;

   // Four N-bit unsigned samples need two extra bits to sum without overflow.
   function automatic int sum_w(input int n);
      return n + 2;
   endfunction

endpackage

// File: rtl/mux_scan_capture_if.sv
// Bus between the scan/capture stage and its mux and result consumer.
interface mux_scan_capture_if
   import mux_scan_pkg::*;
#(
   parameter int N = 5
) ();

   // start is a level sampled on a rising edge with no ready (ignored while
   // scanning); done is a one-cycle valid qualifying max_val/max_idx/sum,
   // which then hold until the next done.
   logic                 start;
   logic [SEL_W-1:0]     mux_sel;
   logic [N-1:0]         mux_out;
   logic                 busy;
   logic                 done;
   logic [N-1:0]         max_val;
   logic [SEL_W-1:0]     max_idx;
   logic [sum_w(N)-1:0]  sum;

   modport master (
      output start, mux_out,
      input  mux_sel, busy, done, max_val, max_idx, sum
   );

   modport slave (
      input  start, mux_out,
      output mux_sel, busy, done, max_val, max_idx, sum
   );

endinterface

// File: rtl/mux_scan_capture_scan_counter.sv
// Source-index counter for the scan: clear, enable, terminal count at LAST_IDX.
module scan_counter
   import mux_scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [SEL_W-1:0] cnt,
   output logic             tc
);

   logic [SEL_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = (cnt_q == LAST_IDX);

endmodule

// File: rtl/mux_scan_capture.sv
// Scans the four mux sources one per cycle and captures max, its index and sum.
module mux_scan_capture
   import mux_scan_pkg::*;
#(
   parameter int N = 5
) (
   input  logic              clk,
   input  logic              rst,
   mux_scan_capture_if.slave bus,
   output logic [1:0]        dbg_state
);

   localparam int SW = sum_w(N);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] SCAN = ST_SCAN;
   localparam logic [1:0] DONE = ST_DONE;

   logic [1:0]       state_q, state_d;
   logic [N-1:0]     acc_max_q, acc_max_d;
   logic [SEL_W-1:0] acc_idx_q, acc_idx_d;
   logic [SW-1:0]    acc_sum_q, acc_sum_d;
   logic [N-1:0]     max_val_q, max_val_d;
   logic [SEL_W-1:0] max_idx_q, max_idx_d;
   logic [SW-1:0]    sum_q, sum_d;

   logic             cnt_clr;
   logic             cnt_en;
   logic [SEL_W-1:0] cnt;
   logic             cnt_tc;

   logic             take;
   logic [N-1:0]     smp_max;
   logic [SEL_W-1:0] smp_idx;
   logic [SW-1:0]    smp_sum;

   scan_counter u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (cnt),
      .tc  (cnt_tc)
   );

   // Strict compare keeps the lowest index on ties; sample 0 always seeds.
   always_comb begin
      take    = (cnt == '0) || (bus.mux_out > acc_max_q);
      smp_max = take ? bus.mux_out : acc_max_q;
      smp_idx = take ? cnt : acc_idx_q;
      smp_sum = acc_sum_q + SW'(bus.mux_out);
   end

   always_comb begin
      state_d   = state_q;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      acc_max_d = acc_max_q;
      acc_idx_d = acc_idx_q;
      acc_sum_d = acc_sum_q;
      max_val_d = max_val_q;
      max_idx_d = max_idx_q;
      sum_d     = sum_q;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d   = SCAN;
               cnt_clr   = 1'b1;
               acc_max_d = '0;
               acc_idx_d = '0;
               acc_sum_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         SCAN: begin
            cnt_en    = 1'b1;
            acc_max_d = smp_max;
            acc_idx_d = smp_idx;
            acc_sum_d = smp_sum;
            if (cnt_tc) begin
               state_d   = DONE;
               max_val_d = smp_max;
               max_idx_d = smp_idx;
               sum_d     = smp_sum;
            end
         end
         default: begin
            state_d   = IDLE;
            cnt_clr   = 1'b1;
            acc_max_d = '0;
            acc_idx_d = '0;
            acc_sum_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         acc_max_q <= '0;
         acc_idx_q <= '0;
         acc_sum_q <= '0;
         max_val_q <= '0;
         max_idx_q <= '0;
         sum_q     <= '0;
      end else begin
         state_q   <= state_d;
         acc_max_q <= acc_max_d;
         acc_idx_q <= acc_idx_d;
         acc_sum_q <= acc_sum_d;
         max_val_q <= max_val_d;
         max_idx_q <= max_idx_d;
         sum_q     <= sum_d;
      end
   end

   // Control outputs decode straight from the state flop, so reset clears them at once.
   assign bus.busy    = (state_q == SCAN);
   assign bus.done    = (state_q == DONE);
   assign bus.mux_sel = (state_q == SCAN) ? cnt : '0;
   assign bus.max_val = max_val_q;
   assign bus.max_idx = max_idx_q;
   assign bus.sum     = sum_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Self-checking bench for mux_scan_capture: behavioural mux, scoreboard of expected results.
module tb_mux_scan_capture;
   import mux_scan_pkg::*;

   localparam int N  = 5;
   localparam int SW = sum_w(N);
   localparam int EW = N + 2 + SW;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;
   logic [N-1:0] src [4];

   always #5 clk = ~clk;

   mux_scan_capture_if #(.N(N)) bus ();

   mux_scan_capture #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   assign bus.mux_out = src[bus.mux_sel];

   logic [EW-1:0] exp_q [$];
   int n_cmp    = 0;
   int n_err    = 0;
   int done_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [EW-1:0] model(input logic [N-1:0] a, b, c, d);
      logic [N-1:0]  v [4];
      logic [N-1:0]  best;
      logic [1:0]    idx;
      logic [SW-1:0] s;
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      best = v[0];
      idx  = 2'd0;
      s    = '0;
      for (int i = 0; i < 4; i++) begin
         s = s + SW'(v[i]);
         if (v[i] > best) begin
            best = v[i];
            idx  = 2'(i);
         end
      end
      return {best, idx, s};
   endfunction

   task automatic set_src(input logic [N-1:0] a, b, c, d);
      src[0] = a; src[1] = b; src[2] = c; src[3] = d;
   endtask

   // Scoreboard side: every done pulse must match the oldest expected result.
   always @(negedge clk) begin : monitor
      logic [EW-1:0] e;
      if (rst === 1'b1 && bus.done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check("max_val", bus.max_val, e[EW-1 -: N]);
            check("max_idx", bus.max_idx, e[SW+1 -: 2]);
            check("sum",     bus.sum,     e[SW-1:0]);
         end
      end
   end

   // Full scan with per-cycle select/busy checks; ends in the DONE cycle.
   task automatic scan_checked(input logic [N-1:0] a, b, c, d);
      set_src(a, b, c, d);
      exp_q.push_back(model(a, b, c, d));
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("scan_sel",  bus.mux_sel, i);
         check("scan_busy", bus.busy, 1);
         @(negedge clk);
      end
      check("done_pulse", bus.done, 1);
      check("done_busy",  bus.busy, 0);
      check("done_sel",   bus.mux_sel, 0);
      @(negedge clk);
      check("post_done", bus.done, 0);
   endtask

   initial begin
      int d0;
      rst       = 1'b0;
      bus.start = 1'b0;
      set_src(0, 0, 0, 0);
      #2;
      check("rst_busy",  bus.busy, 0);
      check("rst_done",  bus.done, 0);
      check("rst_state", dbg_state, 0);
      check("rst_sum",   bus.sum, 0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      check("rel_busy", bus.busy, 0);
      check("rel_done", bus.done, 0);

      // Basic, ties/extremes
      scan_checked(5'd3,  5'd17, 5'd9,  5'd30);
      scan_checked(5'd31, 5'd31, 5'd0,  5'd31);
      scan_checked(5'd0,  5'd0,  5'd0,  5'd0);
      scan_checked(5'd31, 5'd31, 5'd31, 5'd31);
      for (int k = 0; k < 3; k++) begin
         scan_checked(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end

      // start during SCAN is ignored
      d0 = done_cnt;
      set_src(5'd1, 5'd2, 5'd3, 5'd4);
      exp_q.push_back(model(5'd1, 5'd2, 5'd3, 5'd4));
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("ign_done", bus.done, 1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("ign_no_done", bus.done, 0);
         check("ign_no_busy", bus.busy, 0);
      end
      #1 check("ign_done_cnt", done_cnt - d0, 1);

      // Back-to-back: start held into DONE restarts immediately
      set_src(5'd3, 5'd17, 5'd9, 5'd30);
      exp_q.push_back(model(5'd3, 5'd17, 5'd9, 5'd30));
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk) begin
         bus.start = 1'b1;
         exp_q.push_back(model(5'd5, 5'd4, 5'd6, 5'd1));
      end
      @(negedge clk);
      check("b2b_done1", bus.done, 1);
      set_src(5'd5, 5'd4, 5'd6, 5'd1);
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b_busy", bus.busy, 1);
      check("b2b_sel0", bus.mux_sel, 0);
      for (int i = 1; i < 4; i++) begin
         check("b2b_hold_max", bus.max_val, 30);
         check("b2b_hold_sum", bus.sum, 59);
         @(negedge clk);
         check("b2b_sel", bus.mux_sel, i);
      end
      @(negedge clk);
      check("b2b_done2", bus.done, 1);
      @(negedge clk);

      // Reset mid-scan: partial scan discarded, outputs zeroed
      set_src(5'd7, 5'd8, 5'd9, 5'd10);
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_busy",  bus.busy, 0);
      check("mid_sel",   bus.mux_sel, 0);
      check("mid_done",  bus.done, 0);
      check("mid_max",   bus.max_val, 0);
      check("mid_idx",   bus.max_idx, 0);
      check("mid_sum",   bus.sum, 0);
      check("mid_state", dbg_state, 0);
      d0 = done_cnt;
      @(negedge clk);
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("mid_no_done", bus.done, 0);
      end
      #1 check("mid_done_cnt", done_cnt - d0, 0);
      scan_checked(5'd7, 5'd8, 5'd9, 5'd10);

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed %0d compared, required completion", n_cmp);
      $fatal(1);
   end

endmodule
